// File: rtl/gpio_rd_pkg.sv
// Shared address map, widths and types for the GPIO read responder.
package gpio_rd_pkg;

   localparam logic [13:0] ADR_IN0      = 14'h1000;
   localparam logic [13:0] ADR_IN1      = 14'h1004;
   localparam logic [13:0] ADR_DDR_BASE = 14'h1100;
   localparam logic [13:0] ADR_CHG0     = 14'h1200;
   localparam logic [13:0] ADR_CHG1     = 14'h1204;

   localparam int DDR_W = 24;

   typedef logic [DDR_W-1:0] ddr_word_t;

endpackage

// File: rtl/gpio_rd_responder_strobe_sync_edge.sv
// Three-flop synchronizer for an asynchronous bus strobe, with a one-cycle
// pulse on the synchronized rising edge.
module strobe_sync_edge (
   input  logic CLOCK,
   input  logic reset_reg,
   input  logic strobe_i,
   output logic pulse_o
);

   logic [2:0] sync_q;

   // Shift the raw strobe through the synchronizer chain.
   always_ff @(posedge CLOCK or posedge reset_reg) begin
      if (reset_reg) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], strobe_i};
      end
   end

   // Bit 0 may be metastable, so the edge is taken between bits 1 and 2.
   assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/gpio_rd_responder.sv
// GPIO bus-read responder: returns DDR shadow registers, synchronized pin
// levels and sticky read-to-clear change flags. DDR writes are snooped from
// the shared write bus so software can read DDR back.
module gpio_rd_responder
   import gpio_rd_pkg::*;
#(
   parameter int AddrWidth = 14,
   parameter int BusWidth  = 32,
   parameter int GPIOWidth = 36,
   parameter int NumIOReg  = 6
) (
   input  logic                 CLOCK,
   input  logic                 reset_reg,
   input  logic                 read_reg,
   input  logic                 write_reg,
   input  logic [AddrWidth-3:0] busaddress,
   input  logic [BusWidth-1:0]  busdata_in,
   input  logic [GPIOWidth-1:0] io_read_data,
   output logic [BusWidth-1:0]  busdata_out,
   output logic                 busdata_valid
);

   localparam int LO_W   = DDR_W;
   localparam int HI_W   = GPIOWidth - DDR_W;
   localparam int SLOT_W = (NumIOReg > 1) ? $clog2(NumIOReg) : 1;
   localparam logic [AddrWidth-3:0] NUM_SLOTS = NumIOReg[AddrWidth-3:0];

   logic                 rd_pulse;
   logic                 wr_pulse;
   logic [AddrWidth-1:0] busaddr_q;
   ddr_word_t            wdata_q;
   ddr_word_t            ddr_shadow_q [NumIOReg];
   logic [GPIOWidth-1:0] io_s1_q;
   logic [GPIOWidth-1:0] io_s2_q;
   logic [GPIOWidth-1:0] io_prev_q;
   logic [GPIOWidth-1:0] chg_q;
   logic [GPIOWidth-1:0] chg_d;
   logic [GPIOWidth-1:0] delta;
   logic [BusWidth-1:0]  rd_mux_d;
   logic [BusWidth-1:0]  busdata_out_q;
   logic                 valid_q;
   logic [AddrWidth-1:0] ddr_off;
   logic                 ddr_hit;
   logic [SLOT_W-1:0]    ddr_slot;
   logic                 unused_bits;

   strobe_sync_edge u_rd_sync (
      .CLOCK     (CLOCK),
      .reset_reg (reset_reg),
      .strobe_i  (read_reg),
      .pulse_o   (rd_pulse)
   );

   strobe_sync_edge u_wr_sync (
      .CLOCK     (CLOCK),
      .reset_reg (reset_reg),
      .strobe_i  (write_reg),
      .pulse_o   (wr_pulse)
   );

   // Upper write-data bits carry nothing for this block.
   assign unused_bits = ^{busdata_in[BusWidth-1:DDR_W], ddr_off[1:0]};

   // Address and data are captured every cycle; strobes lag them by the
   // synchronizer depth, so both are stable when a pulse arrives.
   always_ff @(posedge CLOCK or posedge reset_reg) begin
      if (reset_reg) begin
         busaddr_q <= '0;
         wdata_q   <= '0;
      end else begin
         busaddr_q <= {busaddress, 2'b00};
         wdata_q   <= busdata_in[DDR_W-1:0];
      end
   end

   assign ddr_off  = busaddr_q - ADR_DDR_BASE;
   assign ddr_hit  = (busaddr_q >= ADR_DDR_BASE) && (ddr_off[AddrWidth-1:2] < NUM_SLOTS);
   assign ddr_slot = ddr_off[SLOT_W+1:2];

   // DDR shadow snoops writes; a read in the same cycle sees the old value.
   always_ff @(posedge CLOCK or posedge reset_reg) begin
      if (reset_reg) begin
         for (int k = 0; k < NumIOReg; k++) ddr_shadow_q[k] <= '0;
      end else if (wr_pulse && ddr_hit) begin
         ddr_shadow_q[ddr_slot] <= wdata_q;
      end
   end

   // Two-flop pin synchronizer plus a delayed copy for change detection.
   always_ff @(posedge CLOCK or posedge reset_reg) begin
      if (reset_reg) begin
         io_s1_q   <= '0;
         io_s2_q   <= '0;
         io_prev_q <= '0;
         chg_q     <= '0;
      end else begin
         io_s1_q   <= io_read_data;
         io_s2_q   <= io_s1_q;
         io_prev_q <= io_s2_q;
         chg_q     <= chg_d;
      end
   end

   assign delta = io_s2_q ^ io_prev_q;

   // Sticky change flags; a clear read reloads its half with this cycle's
   // delta so a change landing during the clear is not lost.
   always_comb begin
      chg_d = chg_q | delta;
      if (rd_pulse && (busaddr_q == ADR_CHG0)) begin
         chg_d[LO_W-1:0] = delta[LO_W-1:0];
      end
      if (rd_pulse && (busaddr_q == ADR_CHG1)) begin
         chg_d[GPIOWidth-1:LO_W] = delta[GPIOWidth-1:LO_W];
      end
   end

   // Read data select; unmapped addresses return zero.
   always_comb begin
      rd_mux_d = '0;
      if (busaddr_q == ADR_IN0) begin
         rd_mux_d[LO_W-1:0] = io_s2_q[LO_W-1:0];
      end else if (busaddr_q == ADR_IN1) begin
         rd_mux_d[HI_W-1:0] = io_s2_q[GPIOWidth-1:LO_W];
      end else if (busaddr_q == ADR_CHG0) begin
         rd_mux_d[LO_W-1:0] = chg_q[LO_W-1:0];
      end else if (busaddr_q == ADR_CHG1) begin
         rd_mux_d[HI_W-1:0] = chg_q[GPIOWidth-1:LO_W];
      end else if (ddr_hit) begin
         rd_mux_d[DDR_W-1:0] = ddr_shadow_q[ddr_slot];
      end
   end

   // Read data is held between reads; valid marks each update for one cycle.
   always_ff @(posedge CLOCK or posedge reset_reg) begin
      if (reset_reg) begin
         busdata_out_q <= '0;
         valid_q       <= 1'b0;
      end else begin
         valid_q <= rd_pulse;
         if (rd_pulse) begin
            busdata_out_q <= rd_mux_d;
         end
      end
   end

   assign busdata_out   = busdata_out_q;
   assign busdata_valid = valid_q;

endmodule

// File: tb/tb_gpio_rd_responder.sv
// Self-checking bench for gpio_rd_responder with a behavioural register model.
module tb_gpio_rd_responder;

   logic        CLOCK = 1'b0;
   logic        reset_reg = 1'b1;
   logic        read_reg = 1'b0;
   logic        write_reg = 1'b0;
   logic [11:0] busaddress = '0;
   logic [31:0] busdata_in = '0;
   logic [35:0] io_read_data = '0;
   logic [31:0] busdata_out;
   logic        busdata_valid;

   int nvec = 0;
   int nerr = 0;

   logic [23:0] shadow_m [6];
   logic [35:0] pins_m;
   logic [35:0] chg_m;

   gpio_rd_responder dut (
      .CLOCK         (CLOCK),
      .reset_reg     (reset_reg),
      .read_reg      (read_reg),
      .write_reg     (write_reg),
      .busaddress    (busaddress),
      .busdata_in    (busdata_in),
      .io_read_data  (io_read_data),
      .busdata_out   (busdata_out),
      .busdata_valid (busdata_valid)
   );

   always #5 CLOCK = ~CLOCK;

   initial begin
      #500000;
      $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "timeout");
   end

   function automatic int ddr_idx(input logic [13:0] a);
      int v;
      v = int'(a);
      if (v >= 'h1100 && v < 'h1100 + 4 * 6 && (v % 4) == 0) return (v - 'h1100) / 4;
      return -1;
   endfunction

   function automatic logic [31:0] model_read(input logic [13:0] a);
      logic [31:0] r;
      int          idx;
      r   = '0;
      idx = ddr_idx(a);
      if (a == 14'h1000) r = {8'h0, pins_m[23:0]};
      else if (a == 14'h1004) r = {20'h0, pins_m[35:24]};
      else if (a == 14'h1200) begin
         r = {8'h0, chg_m[23:0]};
         chg_m[23:0] = '0;
      end else if (a == 14'h1204) begin
         r = {20'h0, chg_m[35:24]};
         chg_m[35:24] = '0;
      end else if (idx >= 0) r = {8'h0, shadow_m[idx]};
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 6; k++) shadow_m[k] = '0;
      chg_m = pins_m;
   endtask

   task automatic set_pins(input logic [35:0] p);
      @(negedge CLOCK);
      chg_m        = chg_m | (pins_m ^ p);
      pins_m       = p;
      io_read_data = p;
      repeat (4) @(posedge CLOCK);
   endtask

   task automatic bus_write(input logic [13:0] addr, input logic [31:0] wd);
      int idx;
      @(negedge CLOCK);
      busaddress = addr[13:2];
      busdata_in = wd;
      write_reg  = 1'b1;
      repeat (3) @(posedge CLOCK);
      #1 write_reg = 1'b0;
      repeat (4) @(posedge CLOCK);
      idx = ddr_idx(addr);
      if (idx >= 0) shadow_m[idx] = wd[23:0];
   endtask

   // Read strobe held for 'hold' edges; optional simultaneous write and pin toggle.
   task automatic bus_xfer(input logic [13:0] addr, input int hold, input logic [35:0] toggle,
                           input bit wr, input logic [31:0] wd,
                           output logic [31:0] data, output int npulse, output int first_edge);
      @(negedge CLOCK);
      busaddress = addr[13:2];
      read_reg   = 1'b1;
      if (wr) begin
         busdata_in = wd;
         write_reg  = 1'b1;
      end
      io_read_data = io_read_data ^ toggle;
      npulse     = 0;
      first_edge = -1;
      data       = '0;
      for (int e = 1; e <= hold + 5; e++) begin
         @(posedge CLOCK);
         #1;
         if (busdata_valid === 1'b1) begin
            npulse++;
            if (first_edge < 0) begin
               first_edge = e;
               data = busdata_out;
            end
         end
         if (e == hold) begin
            read_reg  = 1'b0;
            write_reg = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int np, fe;
      reset_reg = 1'b1;
      pins_m = '0;
      chg_m  = '0;
      model_reset();
      repeat (3) @(posedge CLOCK);
      @(negedge CLOCK);
      nvec++;
      if (busdata_out !== 32'h0) begin
         nerr++; $display("FAIL reset_data: got %h required %h", busdata_out, 32'h0);
      end
      nvec++;
      if (busdata_valid !== 1'b0) begin
         nerr++; $display("FAIL reset_valid: got %b required 0", busdata_valid);
      end
      reset_reg = 1'b0;
      repeat (4) @(posedge CLOCK);
      bus_xfer(14'h1100, 3, '0, 0, '0, d, np, fe);
      nvec++;
      if (d !== model_read(14'h1100)) begin
         nerr++; $display("FAIL reset_rd1100: got %h required %h", d, 32'h0);
      end
      nvec++;
      if (np !== 1) begin
         nerr++; $display("FAIL reset_pulses: got %0d required 1", np);
      end
      nvec++;
      if (fe !== 3) begin
         nerr++; $display("FAIL reset_latency: got edge %0d required edge 3", fe);
      end
   endtask

   task automatic test_shadow();
      logic [31:0] d, exp;
      int np, fe;
      logic [13:0] addrs [4];
      addrs = '{14'h1104, 14'h1100, 14'h1118, 14'h1008};
      bus_write(14'h1104, 32'h00ABCDEF);
      foreach (addrs[i]) begin
         bus_xfer(addrs[i], 3, '0, 0, '0, d, np, fe);
         exp = model_read(addrs[i]);
         nvec++;
         if (d !== exp) begin
            nerr++; $display("FAIL shadow_rd_%h: got %h required %h", addrs[i], d, exp);
         end
         nvec++;
         if (np !== 1) begin
            nerr++; $display("FAIL shadow_pulse_%h: got %0d required 1", addrs[i], np);
         end
      end
      bus_xfer(14'h1104, 3, '0, 0, '0, d, np, fe);
      repeat (5) @(posedge CLOCK);
      #1;
      nvec++;
      if (busdata_out !== 32'h00ABCDEF) begin
         nerr++; $display("FAIL shadow_hold: got %h required %h", busdata_out, 32'h00ABCDEF);
      end
   endtask

   task automatic test_inputs();
      logic [31:0] d, exp;
      int np, fe;
      logic [13:0] addrs [4];
      addrs = '{14'h1000, 14'h1004, 14'h1200, 14'h1204};
      set_pins(36'hF_0000_00A5);
      foreach (addrs[i]) begin
         bus_xfer(addrs[i], 3, '0, 0, '0, d, np, fe);
         exp = model_read(addrs[i]);
         nvec++;
         if (d !== exp) begin
            nerr++; $display("FAIL inputs_rd_%h: got %h required %h", addrs[i], d, exp);
         end
      end
   endtask

   task automatic test_chg();
      logic [31:0] d, exp;
      int np, fe;
      set_pins(pins_m ^ 36'h8);
      for (int i = 0; i < 2; i++) begin
         bus_xfer(14'h1200, 3, '0, 0, '0, d, np, fe);
         exp = model_read(14'h1200);
         nvec++;
         if (d !== exp) begin
            nerr++; $display("FAIL chg_pin3_rd%0d: got %h required %h", i, d, exp);
         end
      end
   endtask

   task automatic test_clear_cycle();
      logic [31:0] d, exp;
      int np, fe;
      exp = model_read(14'h1200);
      bus_xfer(14'h1200, 3, 36'h20, 0, '0, d, np, fe);
      pins_m = pins_m ^ 36'h20;
      chg_m[23:0] = 24'h20;
      nvec++;
      if (d !== exp) begin
         nerr++; $display("FAIL clear_cycle_rd0: got %h required %h", d, exp);
      end
      bus_xfer(14'h1200, 3, '0, 0, '0, d, np, fe);
      exp = model_read(14'h1200);
      nvec++;
      if (d !== exp) begin
         nerr++; $display("FAIL clear_cycle_rd1: got %h required %h", d, exp);
      end
   endtask

   task automatic test_held();
      logic [31:0] d, exp;
      int np, fe;
      bus_xfer(14'h1104, 20, '0, 0, '0, d, np, fe);
      exp = model_read(14'h1104);
      nvec++;
      if (np !== 1) begin
         nerr++; $display("FAIL held_pulses: got %0d required 1", np);
      end
      nvec++;
      if (d !== exp) begin
         nerr++; $display("FAIL held_data: got %h required %h", d, exp);
      end
   endtask

   task automatic test_simultaneous();
      logic [31:0] d, exp;
      int np, fe;
      bus_write(14'h1108, 32'h00123456);
      exp = model_read(14'h1108);
      bus_xfer(14'h1108, 3, '0, 1, 32'hFF654321, d, np, fe);
      shadow_m[2] = 24'h654321;
      nvec++;
      if (d !== exp) begin
         nerr++; $display("FAIL simul_old: got %h required %h", d, exp);
      end
      bus_xfer(14'h1108, 3, '0, 0, '0, d, np, fe);
      exp = model_read(14'h1108);
      nvec++;
      if (d !== exp) begin
         nerr++; $display("FAIL simul_new: got %h required %h", d, exp);
      end
   endtask

   task automatic test_random();
      logic [31:0] d, exp, wd;
      logic [63:0] r;
      logic [13:0] a;
      int np, fe, op, sel;
      logic [13:0] unm [7];
      unm = '{14'h1008, 14'h100C, 14'h1010, 14'h1014, 14'h1118, 14'h0000, 14'h1208};
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 4);
         if (op == 0) begin
            sel = $urandom_range(0, 7);
            if (sel < 6) a = 14'(14'h1100 + 4 * sel);
            else if (sel == 6) a = 14'h1118;
            else a = 14'h1000;
            wd = $urandom;
            bus_write(a, wd);
         end else begin
            if (op == 1) a = 14'(14'h1100 + 4 * $urandom_range(0, 5));
            else if (op == 2) begin
               r = {$urandom, $urandom};
               set_pins(r[35:0]);
               a = ($urandom_range(0, 1) == 0) ? 14'h1000 : 14'h1004;
            end else if (op == 3) a = ($urandom_range(0, 1) == 0) ? 14'h1200 : 14'h1204;
            else a = unm[$urandom_range(0, 6)];
            bus_xfer(a, $urandom_range(3, 6), '0, 0, '0, d, np, fe);
            exp = model_read(a);
            nvec++;
            if (d !== exp || np !== 1) begin
               nerr++;
               $display("FAIL rand_%0d_rd_%h: got %h pulses %0d required %h pulses 1", i, a, d, np, exp);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d, exp;
      int np, fe, nv;
      logic [13:0] addrs [3];
      addrs = '{14'h1200, 14'h1204, 14'h1104};
      set_pins(36'hC_0000_0301);
      @(negedge CLOCK);
      busaddress = 12'h400;
      read_reg   = 1'b1;
      nv = 0;
      @(posedge CLOCK);
      #1 reset_reg = 1'b1;
      for (int e = 2; e <= 10; e++) begin
         @(posedge CLOCK);
         #1;
         if (busdata_valid === 1'b1) nv++;
         if (e == 3) read_reg = 1'b0;
         if (e == 4) reset_reg = 1'b0;
      end
      model_reset();
      nvec++;
      if (nv !== 0) begin
         nerr++; $display("FAIL rstmid_valid: got %0d pulses required 0", nv);
      end
      nvec++;
      if (busdata_out !== 32'h0) begin
         nerr++; $display("FAIL rstmid_data: got %h required %h", busdata_out, 32'h0);
      end
      foreach (addrs[i]) begin
         bus_xfer(addrs[i], 3, '0, 0, '0, d, np, fe);
         exp = model_read(addrs[i]);
         nvec++;
         if (d !== exp) begin
            nerr++; $display("FAIL rstmid_rd_%h: got %h required %h", addrs[i], d, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_shadow();
      test_inputs();
      test_chg();
      test_clear_cycle();
      test_held();
      test_simultaneous();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
